// File: rtl/frame_draw_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : frame_draw_sequencer_pkg
// Brief  : Shared encodings for the frame draw sequencer and its scanner.
// Rev    : 1.0  initial release
// ============================================================================
package frame_draw_sequencer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GROUND_Y = 119;

  localparam logic [2:0] GS_NEUTRAL  = 3'b000;
  localparam logic [2:0] GS_JUMP     = 3'b001;
  localparam logic [2:0] GS_FALL     = 3'b010;
  localparam logic [2:0] GS_GAMEOVER = 3'b011;
  localparam logic [2:0] GS_STARTUP  = 3'b100;

  localparam logic [2:0] COL_ERASE  = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b100;
  localparam logic [2:0] COL_OBST   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE_P = 3'd1,
    S_MOVE_P  = 3'd2,
    S_DRAW_P  = 3'd3,
    S_ERASE_O = 3'd4,
    S_MOVE_O  = 3'd5,
    S_DRAW_O  = 3'd6,
    S_DONE    = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_draw_sequencer_scanner.sv
`default_nettype none
// ============================================================================
// Module : frame_draw_sequencer_scanner
// Brief  : Row-major sprite pixel walker with screen clipping and last flag.
// Rev    : 1.0  initial release
// ============================================================================
module frame_draw_sequencer_scanner
  import frame_draw_sequencer_pkg::*;
#(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [7:0] i_base_x,
  input  logic [7:0] i_base_y,
  output logic [7:0] o_px,
  output logic [7:0] o_py,
  output logic       o_visible,
  output logic       o_last
);

  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = $clog2(SPRITE_H);
  localparam int CW = XB + YB;

  logic [CW-1:0] r_cnt;
  logic [8:0]    w_px;
  logic [8:0]    w_py;

  // Power-of-two sprite area lets the counter wrap to zero on its own.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_px      = {1'b0, i_base_x} + 9'(r_cnt[XB-1:0]);
  assign w_py      = {1'b0, i_base_y} + 9'(r_cnt[CW-1:XB]);
  assign o_px      = w_px[7:0];
  assign o_py      = w_py[7:0];
  assign o_visible = (w_px < 9'(SCREEN_W)) && (w_py < 9'(SCREEN_H));
  assign o_last    = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/frame_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module : frame_draw_sequencer
// Brief  : Per-frame erase/move/draw scheduler owning the VGA plot port.
// Rev    : 1.0  initial release
// ============================================================================
module frame_draw_sequencer
  import frame_draw_sequencer_pkg::*;
#(
  parameter int SPRITE_W       = 8,
  parameter int SPRITE_H       = 8,
  parameter int PLAYER_X       = 20,
  parameter int PLAYER_Y_START = 111,
  parameter int OBST_Y         = 111,
  parameter int OBST_X_START   = 159,
  parameter int HEIGHT_DIFF    = 2,
  parameter int OBST_STEP      = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [2:0] i_game_state,
  input  logic       i_frame_tick,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_plot,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_hit
);

  localparam logic [7:0] c_PLAYER_X    = 8'(PLAYER_X);
  localparam logic [7:0] c_PY_START    = 8'(PLAYER_Y_START);
  localparam logic [7:0] c_PY_FALL_MAX = 8'(PLAYER_Y_START - HEIGHT_DIFF);
  localparam logic [7:0] c_OBST_Y      = 8'(OBST_Y);
  localparam logic [7:0] c_OX_START    = 8'(OBST_X_START);
  localparam logic [7:0] c_HD          = 8'(HEIGHT_DIFF);
  localparam logic [7:0] c_OS          = 8'(OBST_STEP);
  localparam logic [7:0] c_W           = 8'(SPRITE_W);
  localparam logic [7:0] c_H           = 8'(SPRITE_H);

  seq_state_t r_state;
  logic [2:0] r_gs;
  logic [7:0] r_player_y;
  logic [7:0] r_obst_x;
  logic       r_hit;

  logic       w_scan_en;
  logic [7:0] w_base_x;
  logic [7:0] w_base_y;
  logic [2:0] w_colour;
  logic [7:0] w_px;
  logic [7:0] w_py;
  logic       w_visible;
  logic       w_last;
  logic [7:0] w_dx;
  logic [7:0] w_dy;
  logic       w_collide;

  // One scanner serves all four pixel phases; only base and colour change.
  always_comb begin
    w_scan_en = 1'b0;
    w_base_x  = c_PLAYER_X;
    w_base_y  = r_player_y;
    w_colour  = COL_ERASE;
    case (r_state)
      S_ERASE_P: w_scan_en = 1'b1;
      S_DRAW_P: begin
        w_scan_en = 1'b1;
        w_colour  = COL_PLAYER;
      end
      S_ERASE_O: begin
        w_scan_en = 1'b1;
        w_base_x  = r_obst_x;
        w_base_y  = c_OBST_Y;
      end
      S_DRAW_O: begin
        w_scan_en = 1'b1;
        w_base_x  = r_obst_x;
        w_base_y  = c_OBST_Y;
        w_colour  = COL_OBST;
      end
      default: ;
    endcase
  end

  frame_draw_sequencer_scanner #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scanner (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_en      (w_scan_en),
    .i_base_x  (w_base_x),
    .i_base_y  (w_base_y),
    .o_px      (w_px),
    .o_py      (w_py),
    .o_visible (w_visible),
    .o_last    (w_last)
  );

  assign w_dx      = (c_PLAYER_X >= r_obst_x) ? (c_PLAYER_X - r_obst_x) : (r_obst_x - c_PLAYER_X);
  assign w_dy      = (r_player_y >= c_OBST_Y) ? (r_player_y - c_OBST_Y) : (c_OBST_Y - r_player_y);
  assign w_collide = (w_dx < c_W) && (w_dy < c_H);
  assign o_hit     = r_hit;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_gs         <= GS_NEUTRAL;
      r_player_y   <= c_PY_START;
      r_obst_x     <= c_OX_START;
      r_hit        <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_colour     <= '0;
      o_plot       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_plot       <= 1'b0;
      o_frame_done <= 1'b0;
      if (w_scan_en) begin
        o_x      <= w_px;
        o_y      <= w_py;
        o_colour <= w_colour;
        o_plot   <= w_visible;
      end
      case (r_state)
        S_IDLE: begin
          o_busy <= i_frame_tick;
          if (i_frame_tick) begin
            r_gs    <= i_game_state;
            r_state <= S_ERASE_P;
          end
        end
        S_ERASE_P: if (w_last) r_state <= S_MOVE_P;
        S_MOVE_P: begin
          case (r_gs)
            GS_STARTUP: begin
              r_player_y <= c_PY_START;
              r_obst_x   <= c_OX_START;
              r_hit      <= 1'b0;
            end
            GS_JUMP: r_player_y <= (r_player_y < c_HD) ? 8'd0 : (r_player_y - c_HD);
            GS_FALL: r_player_y <= (r_player_y > c_PY_FALL_MAX) ? c_PY_START : (r_player_y + c_HD);
            default: ;
          endcase
          r_state <= S_DRAW_P;
        end
        S_DRAW_P:  if (w_last) r_state <= S_ERASE_O;
        S_ERASE_O: if (w_last) r_state <= S_MOVE_O;
        S_MOVE_O: begin
          if (r_gs != GS_GAMEOVER && r_gs != GS_STARTUP) begin
            r_obst_x <= (r_obst_x < c_OS) ? c_OX_START : (r_obst_x - c_OS);
          end
          r_state <= S_DRAW_O;
        end
        S_DRAW_O:  if (w_last) r_state <= S_DONE;
        S_DONE: begin
          o_frame_done <= 1'b1;
          r_hit        <= r_hit | w_collide;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
